// File: rtl/kvs_pkg.sv
// Shared types and widths for the KVS command arbiter slice.
// Command encodings, response bundle and arbiter state.
package kvs_pkg;

  localparam int KVS_KEY_W  = 128;
  localparam int KVS_VAL_W  = 32;
  localparam int KVS_ADDR_W = 16;

  typedef enum logic [2:0] {
    KVS_SEARCH = 3'd0,
    KVS_UPDATE = 3'd1,
    KVS_WRITE  = 3'd2,
    KVS_ERASE  = 3'd3,
    KVS_READ   = 3'd4
  } kvs_cmd_e;

  typedef enum logic {
    ST_WAIT_READY = 1'b0,
    ST_RUN        = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic                  hit;
    logic                  err;
    logic [KVS_ADDR_W-1:0] addr;
    logic [KVS_VAL_W-1:0]  value;
  } kvs_rsp_t;

  function automatic logic cmd_ok(input logic [2:0] c);
    return c <= 3'd4;
  endfunction

endpackage

// File: rtl/kvs_tag_fifo.sv
// In-order tag FIFO: remembers which requester owns each
// command in flight so acks can be routed back.
module kvs_tag_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wp;
  logic [AW:0]  r_rp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (push) r_wp <= r_wp + (AW+1)'(1);
      if (pop)  r_rp <= r_rp + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) r_mem[r_wp[AW-1:0]] <= din;
  end

  assign dout  = r_mem[r_rp[AW-1:0]];
  assign empty = (r_wp == r_rp);
  assign full  = (r_wp[AW] != r_rp[AW]) &&
                 (r_wp[AW-1:0] == r_rp[AW-1:0]);

endmodule

// File: rtl/kvs_cmd_arbiter.sv
// Round-robin sharing of one KVS kernel command port among
// NUM_REQ requesters, with in-order response routing.
module kvs_cmd_arbiter
  import kvs_pkg::*;
#(
  parameter int NUM_REQ         = 4,
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic                           clk,
  input  logic                           xrst,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [3*NUM_REQ-1:0]           req_cmd,
  input  logic [KVS_KEY_W*NUM_REQ-1:0]   req_key,
  input  logic [KVS_VAL_W*NUM_REQ-1:0]   req_value,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic                           rsp_hit,
  output logic                           rsp_err,
  output logic [KVS_ADDR_W-1:0]          rsp_ent_addr,
  output logic [KVS_VAL_W-1:0]           rsp_value,
  input  logic                           kvs_ready,
  input  logic                           kvs_wait,
  input  logic                           kvs_cmd_full,
  input  logic                           kvs_ack,
  input  logic                           kvs_single_hit,
  input  logic                           kvs_multi_hit,
  input  logic                           kvs_ent_err,
  input  logic [KVS_ADDR_W-1:0]          kvs_ent_addr,
  input  logic [KVS_VAL_W-1:0]           kvs_key_value,
  output logic                           kvs_cmd_valid,
  output logic                           kvs_cmd_search,
  output logic                           kvs_cmd_update,
  output logic                           kvs_cmd_write,
  output logic                           kvs_cmd_erase,
  output logic                           kvs_cmd_read,
  output logic [KVS_KEY_W-1:0]           kvs_key_dat,
  output logic [KVS_VAL_W-1:0]           kvs_key_value_o,
  output logic [6:0]                     outstanding,
  output logic                           idle,
  output logic                           proto_err
);

  localparam int IW = $clog2(NUM_REQ);

  arb_state_e           r_state;
  arb_state_e           w_state_nxt;
  logic [IW-1:0]        r_last;
  logic [6:0]           r_out;
  logic                 r_perr;
  logic                 r_cmd_valid;
  logic [4:0]           r_strb;
  logic [KVS_KEY_W-1:0] r_key;
  logic [KVS_VAL_W-1:0] r_val;
  logic [NUM_REQ-1:0]   r_rsp_valid;
  kvs_rsp_t             r_rsp;

  logic [NUM_REQ-1:0]   w_elig;
  logic                 w_any;
  logic [IW-1:0]        w_idx;
  logic                 w_can;
  logic                 w_grant;
  logic [2:0]           w_cmd;
  logic [IW-1:0]        w_tag;
  logic                 w_empty;
  logic                 w_full;
  logic                 w_pop;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_WAIT_READY: if (kvs_ready)  w_state_nxt = ST_RUN;
      ST_RUN:        if (!kvs_ready) w_state_nxt = ST_WAIT_READY;
      default:       w_state_nxt = ST_WAIT_READY;
    endcase
  end

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++)
      w_elig[i] = req_valid[i] & cmd_ok(req_cmd[3*i +: 3]);
  end

  // Search starts one past the last winner, wrapping at NUM_REQ.
  always_comb begin : p_rr
    int j;
    j     = 0;
    w_any = 1'b0;
    w_idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      j = int'(r_last) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!w_any && w_elig[j]) begin
        w_any = 1'b1;
        w_idx = IW'(j);
      end
    end
  end

  assign w_can   = (r_state == ST_RUN) && !kvs_wait && !kvs_cmd_full &&
                   (r_out < 7'(MAX_OUTSTANDING)) && !w_full;
  assign w_grant = w_can && w_any;
  assign w_cmd   = req_cmd[3*int'(w_idx) +: 3];
  assign w_pop   = kvs_ack && !w_empty;

  always_comb begin
    req_ready = '0;
    if (w_grant) req_ready[w_idx] = 1'b1;
  end

  kvs_tag_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .W     (IW)
  ) u_tags (
    .clk   (clk),
    .rst_n (xrst),
    .push  (w_grant),
    .din   (w_idx),
    .pop   (w_pop),
    .dout  (w_tag),
    .empty (w_empty),
    .full  (w_full)
  );

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      r_state     <= ST_WAIT_READY;
      r_last      <= IW'(NUM_REQ-1);
      r_out       <= '0;
      r_perr      <= 1'b0;
      r_cmd_valid <= 1'b0;
      r_strb      <= '0;
      r_key       <= '0;
      r_val       <= '0;
      r_rsp_valid <= '0;
      r_rsp       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cmd_valid <= w_grant;
      r_strb      <= '0;
      r_rsp_valid <= '0;
      if (w_grant) begin
        r_last <= w_idx;
        r_key  <= req_key[KVS_KEY_W*int'(w_idx) +: KVS_KEY_W];
        r_val  <= req_value[KVS_VAL_W*int'(w_idx) +: KVS_VAL_W];
        unique case (w_cmd)
          KVS_SEARCH: r_strb <= 5'b00001;
          KVS_UPDATE: r_strb <= 5'b00010;
          KVS_WRITE:  r_strb <= 5'b00100;
          KVS_ERASE:  r_strb <= 5'b01000;
          KVS_READ:   r_strb <= 5'b10000;
          default:    r_strb <= 5'b00000;
        endcase
      end
      if (w_pop) begin
        r_rsp_valid[w_tag] <= 1'b1;
        r_rsp <= '{hit:   kvs_single_hit | kvs_multi_hit,
                   err:   kvs_ent_err,
                   addr:  kvs_ent_addr,
                   value: kvs_key_value};
      end
      if (kvs_ack && w_empty) r_perr <= 1'b1;
      if (w_grant && !w_pop)      r_out <= r_out + 7'd1;
      else if (!w_grant && w_pop) r_out <= r_out - 7'd1;
    end
  end

  assign kvs_cmd_valid   = r_cmd_valid;
  assign kvs_cmd_search  = r_strb[0];
  assign kvs_cmd_update  = r_strb[1];
  assign kvs_cmd_write   = r_strb[2];
  assign kvs_cmd_erase   = r_strb[3];
  assign kvs_cmd_read    = r_strb[4];
  assign kvs_key_dat     = r_key;
  assign kvs_key_value_o = r_val;
  assign rsp_valid       = r_rsp_valid;
  assign rsp_hit         = r_rsp.hit;
  assign rsp_err         = r_rsp.err;
  assign rsp_ent_addr    = r_rsp.addr;
  assign rsp_value       = r_rsp.value;
  assign outstanding     = r_out;
  assign proto_err       = r_perr;
  assign idle            = (r_state == ST_RUN) && (r_out == '0) &&
                           !(|req_valid);

endmodule

// File: doc/kvs_cmd_arbiter.md
# kvs_cmd_arbiter

Shares a single Axonerve KVS kernel command/response port among `NUM_REQ` independent requesters, such as parallel search/add engines, a host init/erase path and a readout path. Arbitration is round-robin with one command per cycle, throttled by kernel backpressure and an outstanding-command limit. Kernel responses return in issue order; a tag FIFO routes each `O_ACK` back to the requester that issued the command. The block sits directly between the requester engines and the `axonerve_kvs_kernel` instance.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, 2..8.
- `MAX_OUTSTANDING`, 16: maximum commands in flight, power of two, 2..64.

Ports (`N` = `NUM_REQ`; vectors are flattened with requester i in slice i):
- `clk` in 1: single clock domain, rising edge.
- `xrst` in 1: asynchronous, active-low reset.
- `req_valid` in N: requester i has a command.
- `req_ready` out N: one-hot grant; the command is accepted when `req_valid[i] & req_ready[i]`.
- `req_cmd` in 3N: per-requester command encoding from `kvs_pkg`.
- `req_key` in 128N: key.
- `req_value` in 32N: value.
- `rsp_valid` out N: one-cycle pulse to the requester that owns the response.
- `rsp_hit` out 1: single or multi hit.
- `rsp_err` out 1: `O_ENT_ERR` of the response.
- `rsp_ent_addr` out 16: entry address.
- `rsp_value` out 32: returned key value.
- `kvs_ready`, `kvs_wait`, `kvs_cmd_full` in 1 each: kernel `O_READY`, `O_WAIT`, `O_CMD_FULL`.
- `kvs_ack`, `kvs_single_hit`, `kvs_multi_hit`, `kvs_ent_err` in 1 each: kernel response flags.
- `kvs_ent_addr` in 16, `kvs_key_value` in 32: kernel response data.
- `kvs_cmd_valid`, `kvs_cmd_search`, `kvs_cmd_update`, `kvs_cmd_write`, `kvs_cmd_erase`, `kvs_cmd_read` out 1 each: kernel command strobes.
- `kvs_key_dat` out 128, `kvs_key_value_o` out 32: kernel command data.
- `outstanding` out 7: number of commands in flight.
- `idle` out 1: `RUN`, outstanding = 0, and no `req_valid`.
- `proto_err` out 1: sticky; set by an ack with the tag FIFO empty.

## Operation
- State machine:
  - `WAIT_READY`: the reset state. Moves to `RUN` when `kvs_ready` = 1.
  - `RUN`: if `kvs_ready` drops, moves to `WAIT_READY`. In-flight acks are still routed there; no new grants are made.
- Grant condition: `RUN` & !`kvs_wait` & !`kvs_cmd_full` & outstanding < `MAX_OUTSTANDING` & |`req_valid`.
- `req_ready` is combinational from that condition and the round-robin pointer.
- Round-robin: the search starts at `last_grant+1` modulo N. `last_grant` updates only on a grant. Its reset value is N-1, so requester 0 has first priority.
- On a grant:
  - Register the command onto the kernel bus.
  - Assert exactly one decoded strobe together with `kvs_cmd_valid` for one cycle.
  - Push the requester index onto the tag FIFO.
  - Increment `outstanding`.
- Invalid `req_cmd` encodings: `req_ready` stays low for that requester; it is skipped in arbitration.
- On `kvs_ack`:
  - Pop the tag.
  - Register the response data.
  - Pulse `rsp_valid[tag]`.
  - Decrement `outstanding`.
- Grant and ack in the same cycle: the FIFO pushes and pops together; `outstanding` is unchanged.
- Ack with the tag FIFO empty: set `proto_err`; drive no `rsp_valid`; `outstanding` stays 0 and does not wrap.
- Data registers (`kvs_key_dat`, `rsp_*` data) hold their last value when the matching valid is low.

## Timing
- Grant cycle T gives `kvs_cmd_valid` in T+1. Throughput is one command per cycle.
- `kvs_ack` in cycle T gives `rsp_valid` in T+1. Responses follow strict issue order.
- `kvs_wait` or `kvs_cmd_full` high in cycle T: no grant in T. A command already registered in T is not retracted.
- Reset values: all outputs 0; the state is `WAIT_READY`; the tag FIFO is empty; `last_grant` = N-1. `idle` = 0 until `RUN`.
- Reset mid-operation: all in-flight tags are discarded and no `rsp_valid` is produced for them. Requesters must also be reset.

## Structure
- `kvs_pkg` holds:
  - `kvs_cmd_e`: SEARCH=0, UPDATE=1, WRITE=2, ERASE=3, READ=4; 5–7 invalid.
  - `KVS_KEY_W`=128, `KVS_VAL_W`=32, `KVS_ADDR_W`=16.
- Sub-module `kvs_tag_fifo`:
  - Synchronous FIFO, depth `MAX_OUTSTANDING`, width `$clog2(NUM_REQ)`.
  - Async active-low reset.
  - Supports simultaneous push and pop, and reports `empty`/`full`.

## Test plan
- Reset release with `kvs_ready` = 0 for 10 cycles, then 1; requester 0 issues SEARCH key=0x1, value=0x5 → no grant before ready; `kvs_cmd_valid` & `kvs_cmd_search` one cycle after the grant; key/value driven correctly.
- All 4 requesters hold `req_valid` for 8 cycles → grants in order 0,1,2,3,0,1,2,3. The kernel model acks with 3-cycle latency → `rsp_valid` pulses for 0,1,2,3,... each one cycle after its ack.
- `MAX_OUTSTANDING`=16 with acks withheld → exactly 16 grants and `outstanding`=16. One ack → one more grant in the following cycle.
- Ack and grant in the same cycle while `outstanding`=5 → `outstanding` stays 5 and the tag order is preserved.
- `kvs_cmd_full` pulsed in alternating cycles under continuous requests → grants only in cycles with `kvs_cmd_full` = 0; no command is dropped.
- Spurious ack with nothing outstanding → `proto_err`=1, no `rsp_valid`, `outstanding`=0. `xrst` asserted mid-burst → all outputs 0 immediately, and the block returns to `WAIT_READY`.
